// File: rtl/matvec_operand_loader.sv
// Operand frame loader for the 3x5 matrix-vector multiplier: assembles a serial
// word stream into matrix/vector registers and holds them behind a valid/ready handshake.
module matvec_operand_loader #(
  parameter int M_ROWS = 3,
  parameter int M_COLS = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] matrix [0:M_ROWS-1][0:M_COLS-1],
  output logic signed [DATA_W-1:0] vector [0:M_ROWS-1],
  output logic                     frame_err,
  output logic [15:0]              frame_cnt
);

  localparam int N     = M_ROWS * M_COLS + M_ROWS;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {LOAD, DISCARD, HOLD} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] idx, next_idx;
  logic             accept, wr_en, err_next, cnt_inc;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // flush overrides everything, including a handshake in the same cycle
  always_comb begin
    next_state = state;
    next_idx   = idx;
    wr_en      = 1'b0;
    err_next   = 1'b0;
    cnt_inc    = 1'b0;
    if (flush) begin
      next_state = LOAD;
      next_idx   = '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            wr_en = 1'b1;
            if (idx == LAST_IDX) begin
              next_idx = '0;
              if (in_last) begin
                next_state = HOLD;
                cnt_inc    = 1'b1;
              end else begin
                next_state = DISCARD;
                err_next   = 1'b1;
              end
            end else if (in_last) begin
              next_idx = '0;
              err_next = 1'b1;
            end else begin
              next_idx = idx + 1'b1;
            end
          end
        end
        DISCARD: begin
          if (accept && in_last) next_state = LOAD;
        end
        HOLD: begin
          if (out_ready) next_state = LOAD;
        end
        default: next_state = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= next_state;
      idx       <= next_idx;
      frame_err <= err_next;
      if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // words land directly in the output registers, matrix row-major then vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M_ROWS; i++) begin
        vector[i] <= '0;
        for (int j = 0; j < M_COLS; j++) matrix[i][j] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < M_ROWS; i++) begin
        if (idx == IDX_W'(M_ROWS * M_COLS + i)) vector[i] <= in_data;
        for (int j = 0; j < M_COLS; j++)
          if (idx == IDX_W'(i * M_COLS + j)) matrix[i][j] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_matvec_operand_loader.sv
// Self-checking bench for matvec_operand_loader: directed scenarios plus randomized
// frames, compared against a word-queue model of the framing rules.
module tb_matvec_operand_loader;

  localparam int M_ROWS = 3;
  localparam int M_COLS = 5;
  localparam int DATA_W = 32;
  localparam int N      = M_ROWS * M_COLS + M_ROWS;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, in_last, out_valid, out_ready, frame_err;
  logic signed [DATA_W-1:0] in_data;
  logic signed [DATA_W-1:0] matrix [0:M_ROWS-1][0:M_COLS-1];
  logic signed [DATA_W-1:0] vector [0:M_ROWS-1];
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // model: words of the frame in progress, last completed frame, counters
  logic signed [DATA_W-1:0] cur [$];
  logic signed [DATA_W-1:0] exp_flat [0:N-1];
  bit  discarding, m_hold, gap_en;
  int  exp_cnt;

  matvec_operand_loader #(.M_ROWS(M_ROWS), .M_COLS(M_COLS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .matrix(matrix), .vector(vector), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic signed [DATA_W-1:0] d,
                               input logic last, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_last   = last;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    cur.delete();
    discarding = 0;
    m_hold     = 0;
    exp_cnt    = 0;
    for (int k = 0; k < N; k++) exp_flat[k] = '0;
  endtask

  task automatic modelAccept(input logic signed [DATA_W-1:0] d, input logic last, output logic err);
    err = 1'b0;
    if (discarding) begin
      if (last) discarding = 0;
    end else begin
      cur.push_back(d);
      if (last) begin
        if (cur.size() == N) begin
          for (int k = 0; k < N; k++) exp_flat[k] = cur[k];
          exp_cnt = (exp_cnt + 1) % 65536;
          m_hold  = 1;
        end else begin
          err = 1'b1;
        end
        cur.delete();
      end else if (cur.size() == N) begin
        err = 1'b1;
        cur.delete();
        discarding = 1;
      end
    end
  endtask

  task automatic checkData();
    for (int i = 0; i < M_ROWS; i++) begin
      checkOutput($sformatf("vector[%0d]", i), vector[i], exp_flat[M_ROWS * M_COLS + i]);
      for (int j = 0; j < M_COLS; j++)
        checkOutput($sformatf("matrix[%0d][%0d]", i, j), matrix[i][j], exp_flat[i * M_COLS + j]);
    end
  endtask

  task automatic sendWord(input logic signed [DATA_W-1:0] d, input logic last);
    logic err;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        applyStimulus(1'b0, $urandom, 1'($urandom), 1'b0, 1'b0);
        checkOutput("gap_frame_err", frame_err, 1'b0);
        checkOutput("gap_out_valid", out_valid, m_hold);
      end
    end
    checkOutput("in_ready", in_ready, 1'b1);
    applyStimulus(1'b1, d, last, 1'($urandom), 1'b0);
    modelAccept(d, last, err);
    checkOutput("frame_err", frame_err, err);
    checkOutput("out_valid", out_valid, m_hold);
  endtask

  task automatic sendGood();
    for (int k = 0; k < N; k++) sendWord($urandom, k == N - 1);
  endtask

  task automatic releaseHold(input int wait_n);
    checkOutput("hold_out_valid", out_valid, 1'b1);
    checkOutput("hold_in_ready", in_ready, 1'b0);
    checkOutput("frame_cnt", frame_cnt, exp_cnt);
    checkData();
    for (int w = 0; w < wait_n; w++) begin
      applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'b0, 1'b0);
      checkOutput("stall_out_valid", out_valid, 1'b1);
      checkOutput("stall_in_ready", in_ready, 1'b0);
      checkData();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    m_hold = 0;
    checkOutput("release_out_valid", out_valid, 1'b0);
    checkOutput("release_in_ready", in_ready, 1'b1);
  endtask

  task automatic doFlush(input logic ordy);
    applyStimulus(1'b1, $urandom, 1'($urandom), ordy, 1'b1);
    cur.delete();
    discarding = 0;
    m_hold     = 0;
    checkOutput("flush_frame_err", frame_err, 1'b0);
    checkOutput("flush_out_valid", out_valid, 1'b0);
    checkOutput("flush_in_ready", in_ready, 1'b1);
    checkOutput("flush_frame_cnt", frame_cnt, exp_cnt);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
    checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
    checkOutput({tag, "_frame_err"}, frame_err, 1'b0);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, 16'd0);
    checkData();
  endtask

  initial begin
    logic signed [DATA_W-1:0] extra;
    int kind, len;
    gap_en = 0;
    in_valid = 0; in_data = '0; in_last = 0; out_ready = 0; flush = 0;
    rst_n = 1'b1;
    modelReset();
    #1 rst_n = 1'b0;
    #2 checkResetValues("reset");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] frame 1..18 with immediate out_ready");
    for (int k = 0; k < N; k++) sendWord(k + 1, k == N - 1);
    checkOutput("m00", matrix[0][0], 1);
    checkOutput("m04", matrix[0][4], 5);
    checkOutput("m24", matrix[2][4], 15);
    checkOutput("v0", vector[0], 16);
    checkOutput("v2", vector[2], 18);
    checkOutput("cnt1", frame_cnt, 16'd1);
    releaseHold(0);

    $display("[TB] stalled consumer then back-to-back negative frame");
    for (int k = 0; k < N; k++) sendWord(k + 1, k == N - 1);
    releaseHold(10);
    for (int k = 0; k < N; k++) sendWord(-(k + 1), k == N - 1);
    checkOutput("neg_v2", vector[2], -18);
    checkOutput("neg_m00", matrix[0][0], -1);
    releaseHold(0);

    $display("[TB] early last on idx 7");
    for (int k = 0; k < 8; k++) sendWord(k + 200, k == 7);
    sendGood();
    releaseHold(1);

    $display("[TB] overrun then 4 discarded words");
    for (int k = 0; k < N + 4; k++) sendWord(k + 300, k == N + 3);
    sendGood();
    releaseHold(0);

    $display("[TB] flush mid-frame and during hold");
    for (int k = 0; k < 10; k++) sendWord(k + 400, 1'b0);
    doFlush(1'b0);
    sendGood();
    doFlush(1'b1);
    sendGood();
    releaseHold(2);

    $display("[TB] asynchronous reset mid-frame");
    for (int k = 0; k < 6; k++) sendWord(k + 500, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkResetValues("midreset");
    #1 rst_n = 1'b1;
    for (int k = 0; k < N; k++) sendWord(k + 600, k == N - 1);
    checkOutput("rst_m00", matrix[0][0], 600);
    checkOutput("rst_cnt", frame_cnt, 16'd1);
    releaseHold(0);

    $display("[TB] randomized frames");
    gap_en = 1;
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          sendGood();
          releaseHold($urandom_range(0, 3));
        end
        1: begin
          len = $urandom_range(1, N - 1);
          for (int k = 0; k < len; k++) sendWord($urandom, k == len - 1);
        end
        2: begin
          len = N + $urandom_range(1, 5);
          for (int k = 0; k < len; k++) sendWord($urandom, k == len - 1);
        end
        default: begin
          len = $urandom_range(0, N - 1);
          for (int k = 0; k < len; k++) sendWord($urandom, 1'b0);
          doFlush(1'($urandom));
        end
      endcase
    end
    extra = $urandom;
    for (int k = 0; k < N; k++) sendWord((k == 0) ? extra : $urandom, k == N - 1);
    checkOutput("final_m00", matrix[0][0], extra);
    releaseHold(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
